// File: rtl/multi_channel_transient_monitor.sv
// Per-channel level-change monitor: each change opens a transient window of delay_sel*SCALE+1 cycles.
// Optional SYNC2_EN adds a 2-flop input synchroniser ahead of change detection.
module multi_channel_transient_monitor #(
  parameter int CHANNELS = 8,
  parameter int DLY_W    = 4,
  parameter int SCALE    = 10000,
  parameter int CNT_W    = 18,
  parameter int EVT_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [CHANNELS-1:0] sig_in,
  input  logic [DLY_W-1:0]    delay_sel,
  input  logic                retrig,
  input  logic                clear,
  output logic [CHANNELS-1:0] transient,
  output logic                any_transient,
  output logic [CHANNELS-1:0] seen,
  output logic [EVT_W-1:0]    event_count
);

  typedef enum logic {IDLE = 1'b0, TRANSIENT = 1'b1} state_t;

  localparam int              PW      = DLY_W + 32;
  localparam logic [PW-1:0]   SCALE_W = PW'(SCALE);
  localparam logic [PW-1:0]   CNT_MAX = PW'({CNT_W{1'b1}});

  // Full-width product, clamped to the largest countdown the counters can hold.
  function automatic logic [CNT_W-1:0] sat_load(input logic [DLY_W-1:0] d);
    logic [PW-1:0] prod;
    prod = PW'(d) * SCALE_W;
    if (prod > CNT_MAX) sat_load = '1;
    else                sat_load = prod[CNT_W-1:0];
  endfunction

  logic [CHANNELS-1:0] s, prev, chg, entry, nxt_active;
  logic [1:0]          prime_cnt;
  logic                primed;
  logic [CNT_W-1:0]    load;
  state_t              state [CHANNELS];
  logic [CNT_W-1:0]    cnt   [CHANNELS];

`ifdef SYNC2_EN
  localparam logic [1:0] PRIME_CYC = 2'd3;
  logic [CHANNELS-1:0] sync_p0, sync_p1;

  // Synchroniser stages p0 -> p1
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= sig_in;
      sync_p1 <= sync_p0;
    end
  end
  assign s = sync_p1;
`else
  localparam logic [1:0] PRIME_CYC = 2'd1;
  assign s = sig_in;
`endif

  // No change is reported until prev holds a genuine sample of s.
  assign primed = (prime_cnt == PRIME_CYC);
  assign chg    = primed ? (s ^ prev) : '0;
  assign load   = sat_load(delay_sel);

  always_comb begin
    entry      = '0;
    nxt_active = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      entry[i] = en && (state[i] == IDLE) && chg[i];
      if (state[i] == IDLE) nxt_active[i] = en && chg[i];
      else                  nxt_active[i] = en && ((retrig && chg[i]) || (cnt[i] != '0));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev          <= '0;
      prime_cnt     <= '0;
      transient     <= '0;
      any_transient <= 1'b0;
      seen          <= '0;
      event_count   <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      prev <= s;
      if (!primed) prime_cnt <= prime_cnt + 2'd1;
      transient     <= nxt_active;
      any_transient <= |nxt_active;
      for (int i = 0; i < CHANNELS; i++) begin
        if (!en) begin
          state[i] <= IDLE;
          cnt[i]   <= load;
        end else begin
          case (state[i])
            IDLE: begin
              cnt[i] <= load;
              if (chg[i]) state[i] <= TRANSIENT;
            end
            TRANSIENT: begin
              if (retrig && chg[i])  cnt[i]   <= load;
              else if (cnt[i] == '0) state[i] <= IDLE;
              else                   cnt[i]   <= cnt[i] - CNT_W'(1);
            end
            default: state[i] <= IDLE;
          endcase
        end
      end
      // clear takes priority over a same-cycle entry
      if (clear) begin
        seen        <= '0;
        event_count <= '0;
      end else begin
        seen <= seen | entry;
        if ((|entry) && (event_count != '1)) event_count <= event_count + EVT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_transient_monitor.sv
// Self-checking bench: directed vector table and sequences, then random stimulus against a remaining-cycles model.
module tb_multi_channel_transient_monitor;
  localparam int CH = 4, DW = 4, SC = 4, CW = 18, EW = 8;

  logic          clk = 1'b0;
  logic          reset, en, retrig, clear;
  logic [CH-1:0] sig_in;
  logic [DW-1:0] delay_sel;
  logic [CH-1:0] transient, seen;
  logic          any_transient;
  logic [EW-1:0] event_count;
  logic [CH-1:0] s_transient, s_seen;
  logic          s_any;
  logic [EW-1:0] s_evt;

  always #5 clk = ~clk;

  multi_channel_transient_monitor #(.CHANNELS(CH), .DLY_W(DW), .SCALE(SC), .CNT_W(CW), .EVT_W(EW)) dut (
    .clk(clk), .reset(reset), .en(en), .sig_in(sig_in), .delay_sel(delay_sel), .retrig(retrig),
    .clear(clear), .transient(transient), .any_transient(any_transient), .seen(seen),
    .event_count(event_count));

  multi_channel_transient_monitor #(.CHANNELS(CH), .DLY_W(DW), .SCALE(SC), .CNT_W(4), .EVT_W(EW)) dut_sat (
    .clk(clk), .reset(reset), .en(en), .sig_in(sig_in), .delay_sel(delay_sel), .retrig(retrig),
    .clear(clear), .transient(s_transient), .any_transient(s_any), .seen(s_seen),
    .event_count(s_evt));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: each channel tracks how many more cycles its window stays open.
  logic [CH-1:0] m_prev, m_seen, m_chg, m_ent;
  logic          m_primed;
  int            m_rem [CH];
  int            m_evt;

  function automatic int m_load(input int d);
    int l;
    l = d * SC;
    if (l > (1 << CW) - 1) l = (1 << CW) - 1;
    return l;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_prev = '0; m_primed = 1'b0; m_seen = '0; m_evt = 0;
      for (int i = 0; i < CH; i++) m_rem[i] = 0;
    end else begin
      m_chg = m_primed ? (sig_in ^ m_prev) : '0;
      m_ent = '0;
      for (int i = 0; i < CH; i++) begin
        if (!en) m_rem[i] = 0;
        else if (m_rem[i] == 0) begin
          if (m_chg[i]) begin
            m_rem[i] = m_load(int'(delay_sel)) + 1;
            m_ent[i] = 1'b1;
          end
        end else if (retrig && m_chg[i]) m_rem[i] = m_load(int'(delay_sel)) + 1;
        else m_rem[i] = m_rem[i] - 1;
      end
      if (clear) begin
        m_seen = '0; m_evt = 0;
      end else begin
        m_seen = m_seen | m_ent;
        if (m_ent != '0 && m_evt < (1 << EW) - 1) m_evt = m_evt + 1;
      end
      m_prev = sig_in; m_primed = 1'b1;
    end
  end

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; sig_in = '0; delay_sel = '0; retrig = 1'b0; clear = 1'b0;
    tick(); tick();
    check("reset_transient", transient, 0);
    check("reset_any", any_transient, 0);
    check("reset_seen", seen, 0);
    check("reset_event_count", event_count, 0);
    reset = 1'b0;
    tick();
  endtask

  // Counts consecutive high cycles of transient[ch]; toggles the input again at offset gap if gap>0.
  task automatic measure(input int ch, input int gap, output int len);
    len = 0;
    for (int k = 0; k < 64; k++) begin
      if (!transient[ch]) break;
      len++;
      if (k == gap - 1) sig_in[ch] = ~sig_in[ch];
      tick();
    end
  endtask

  typedef struct {
    logic [3:0] sig;
    logic       clr;
    logic [3:0] tr;
    logic [7:0] evt;
    logic [3:0] sn;
  } vec_t;
  vec_t vt [10];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int len;
    logic [CH-1:0] exp_tr;

    vt[0] = '{4'h0, 1'b0, 4'h0, 8'd0, 4'h0};
    vt[1] = '{4'hF, 1'b0, 4'hF, 8'd1, 4'hF};
    vt[2] = '{4'hF, 1'b0, 4'hF, 8'd1, 4'hF};
    vt[3] = '{4'hF, 1'b0, 4'hF, 8'd1, 4'hF};
    vt[4] = '{4'hF, 1'b0, 4'hF, 8'd1, 4'hF};
    vt[5] = '{4'hF, 1'b0, 4'hF, 8'd1, 4'hF};
    vt[6] = '{4'hF, 1'b0, 4'h0, 8'd1, 4'hF};
    vt[7] = '{4'hE, 1'b1, 4'h1, 8'd0, 4'h0};
    vt[8] = '{4'hE, 1'b0, 4'h1, 8'd0, 4'h0};
    vt[9] = '{4'hC, 1'b0, 4'h3, 8'd1, 4'h2};

    reset = 1'b1; en = 1'b0; sig_in = '0; delay_sel = '0; retrig = 1'b0; clear = 1'b0;

    // Single pulse
    do_reset();
    en = 1'b1; delay_sel = 4'd2;
    sig_in[0] = 1'b1;
    tick();
    check("t1_any_start", any_transient, 1);
    measure(0, 0, len);
    check("t1_length", len, 9);
    check("t1_any_end", any_transient, 0);
    check("t1_event_count", event_count, 1);
    check("t1_seen", seen, 4'b0001);

    // Retrigger on, then off
    do_reset();
    en = 1'b1; delay_sel = 4'd2; retrig = 1'b1;
    sig_in[1] = ~sig_in[1];
    tick();
    measure(1, 5, len);
    check("t2_retrig_length", len, 14);
    check("t2_retrig_event_count", event_count, 1);
    do_reset();
    en = 1'b1; delay_sel = 4'd2; retrig = 1'b0;
    sig_in[1] = ~sig_in[1];
    tick();
    measure(1, 5, len);
    check("t2_noretrig_length", len, 9);
    tick(); tick();
    check("t2_no_reentry", transient, 0);
    check("t2_noretrig_event_count", event_count, 1);

    // Simultaneous entries and clear priority
    do_reset();
    en = 1'b1; delay_sel = 4'd1;
    for (int i = 0; i < 10; i++) begin
      sig_in = vt[i].sig; clear = vt[i].clr;
      tick();
      check("t3_transient", transient, vt[i].tr);
      check("t3_event_count", event_count, vt[i].evt);
      check("t3_seen", seen, vt[i].sn);
    end
    clear = 1'b0;

    // Zero-length window
    do_reset();
    en = 1'b1; delay_sel = 4'd0;
    sig_in[2] = 1'b1;
    tick();
    measure(2, 0, len);
    check("t4_zero_delay_length", len, 1);

    // Load saturation on the narrow-counter build
    do_reset();
    en = 1'b1; delay_sel = 4'd15;
    sig_in[3] = 1'b1;
    tick();
    len = 0;
    for (int k = 0; k < 64; k++) begin
      if (!s_transient[3]) break;
      len++;
      tick();
    end
    check("t4_saturated_length", len, 16);

    // Event counter saturation
    do_reset();
    en = 1'b1; delay_sel = 4'd0;
    for (int k = 0; k < 300; k++) begin
      sig_in[0] = ~sig_in[0];
      tick(); tick();
      if (k == 253) check("t4_event_count_254", event_count, 254);
      if (k == 254) check("t4_event_count_255", event_count, 255);
    end
    check("t4_event_count_sat", event_count, 255);

    // Enable drop, re-enable with steady input, reset with inputs high
    do_reset();
    en = 1'b1; delay_sel = 4'd2;
    sig_in[3] = 1'b1;
    tick(); tick();
    check("t5_active", transient, 4'b1000);
    en = 1'b0;
    tick();
    check("t5_en_low_transient", transient, 0);
    check("t5_en_low_any", any_transient, 0);
    check("t5_en_low_seen", seen, 4'b1000);
    check("t5_en_low_event_count", event_count, 1);
    sig_in[3] = 1'b0;
    tick(); tick();
    en = 1'b1;
    tick(); tick(); tick();
    check("t5_reenable_transient", transient, 0);
    check("t5_reenable_event_count", event_count, 1);
    reset = 1'b1; sig_in = 4'hF;
    tick(); tick();
    reset = 1'b0; en = 1'b1; delay_sel = 4'd1;
    tick();
    check("t5_post_reset_transient_a", transient, 0);
    tick(); tick();
    check("t5_post_reset_transient_b", transient, 0);
    check("t5_post_reset_event_count", event_count, 0);

    // Random stimulus against the model
    do_reset();
    en = 1'b1; delay_sel = 4'd1;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 399) == 0);
      en    = ($urandom_range(0, 15) != 0);
      for (int b = 0; b < CH; b++)
        if ($urandom_range(0, 7) == 0) sig_in[b] = ~sig_in[b];
      if ($urandom_range(0, 31) == 0) delay_sel = DW'($urandom_range(0, 3));
      if ($urandom_range(0, 63) == 0) retrig = ~retrig;
      clear = ($urandom_range(0, 63) == 0);
      tick();
      for (int i = 0; i < CH; i++) exp_tr[i] = (m_rem[i] > 0);
      check("rnd_transient", transient, exp_tr);
      check("rnd_any", any_transient, (exp_tr != '0));
      check("rnd_seen", seen, m_seen);
      check("rnd_event_count", event_count, m_evt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_channel_transient_monitor.md
Name: multi_channel_transient_monitor

Overview:
N-channel successor to the single-bus state monitor. Each input channel independently detects a level change and flags a transient window of programmable length.
Adds a retrigger mode, per-channel sticky "seen" flags and a saturating event counter.
Sits between the pad-side inputs and the status outputs / LED drivers.

Parameters:
CHANNELS, 8, number of independent monitored inputs
DLY_W, 4, width of the delay-select input
SCALE, 10000, clock ticks per delay unit (10 kHz clock gives 1 s per unit)
CNT_W, 18, per-channel countdown width; must hold (2^DLY_W-1)*SCALE
EVT_W, 8, event counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
en  in  1  monitor enable
sig_in  in  CHANNELS  monitored signals
delay_sel  in  DLY_W  transient length in SCALE units, shared by all channels
retrig  in  1  1 = a change during a transient reloads that channel's counter; 0 = ignore it
clear  in  1  clears seen and event_count
transient  out  CHANNELS  per-channel transient-active flags (registered)
any_transient  out  1  OR of transient (registered)
seen  out  CHANNELS  sticky flags: the channel has entered a transient since the last clear
event_count  out  EVT_W  saturating count of cycles in which at least one channel went IDLE->TRANSIENT

Behaviour:
- Reset (synchronous, active-high, clock clk):
  - All outputs are 0.
  - All counters, the prev register and primed are 0.
  - All channels are in IDLE.
- Sample and change detect:
  - s = sig_in, or the synchronised value when SYNC2_EN is defined.
  - prev <= s every cycle, whether or not en is high.
  - chg = s ^ prev, gated by primed.
  - primed goes to 1 on the first cycle after reset. No change is detected in that cycle.
- Load value: L = delay_sel*SCALE, computed at full width, then saturated to 2^CNT_W-1 if it overflows CNT_W.
- Per-channel FSM, states IDLE and TRANSIENT:
  - IDLE: cnt <= L. If en && chg[i], go to TRANSIENT.
  - TRANSIENT:
    - If retrig && chg[i]: cnt <= L and stay in TRANSIENT.
    - Else if cnt==0: go to IDLE.
    - Else: cnt <= cnt-1.
  - transient[i] = (state==TRANSIENT).
  - Latency: change on sig_in at edge k gives transient high from edge k+1. It stays high for L+1 cycles without retrigger (L=0 gives 1 cycle).
- A change while in TRANSIENT with retrig=0 is ignored. It does not re-enter TRANSIENT after expiry.
- en low:
  - Every channel goes to IDLE on the next edge and transient clears.
  - seen and event_count hold.
  - prev keeps tracking, so re-enabling causes no spurious transient.
- delay_sel change mid-transient: affects only subsequent loads and reloads.
- seen[i] is set on the IDLE->TRANSIENT transition.
- event_count:
  - Increments by exactly 1 per cycle in which any channel goes IDLE->TRANSIENT, regardless of how many channels do so.
  - Retrigger reloads do not count.
  - Saturates at 2^EVT_W-1.
- clear:
  - seen and event_count go to 0 on the next edge.
  - If clear and a new entry occur in the same cycle, clear wins: that entry is neither counted nor marked seen.
- Reset mid-transient: all state returns to the reset values on the next edge.

Optional Feature:
SYNC2_EN
- Defined:
  - sig_in passes through a 2-flop synchroniser before change detection, adding 2 cycles of input latency.
  - Synchroniser flops reset to 0.
  - primed covers the first 3 cycles after reset.
- Undefined:
  - sig_in is used directly, for inputs already synchronous to clk.

Test Plan:
Bench parameters SCALE=4, CHANNELS=4, SYNC2_EN undefined.
1. Single pulse: en=1, delay_sel=2, toggle sig_in[0] 0->1 -> transient[0] high for exactly 9 cycles starting the next edge; any_transient matches; event_count=1; seen=4'b0001.
2. Retrigger: delay_sel=2, retrig=1, toggle sig_in[1] at t=0 and t=5 -> transient[1] stays high 14 cycles; event_count=1. Same stimulus with retrig=0 -> 9 cycles.
3. Simultaneous entries: toggle sig_in[3:0] all in one cycle -> transient=4'b1111; event_count increments by 1; seen=4'hF. Assert clear in the same cycle as a later entry -> event_count=0, seen=0.
4. Boundaries: delay_sel=0 -> 1-cycle transient. Use DLY_W=4, CNT_W=4 build with delay_sel=15 -> L saturates to 15 (16 cycles). Drive 300 entries -> event_count holds at 255.
5. Enable and reset: drop en mid-transient -> transient=0 next edge, seen held. Re-raise en with a steady input -> no transient. Reset with sig_in=4'hF held -> no transient after reset release.
